// File: rtl/load_store_unit_pkg.sv
// Shared width constants, RISC-V funct3 codes and decode helpers for the load/store unit.
package load_store_unit_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;
    localparam int WE_W   = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Worst case 3 + 4 - 1 = 6 still fits in three bits.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + access_size(f3) - 3'd1) > 3'd3;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data rotation, per-lane byte enables and load extraction/extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] lo_word_i,
    input  logic [WORD_W-1:0] hi_word_i,
    output logic [WORD_W-1:0] wdata_rot_o,
    output logic [WE_W-1:0]   we_lo_o,
    output logic [WE_W-1:0]   we_hi_o,
    output logic [WORD_W-1:0] rdata_ext_o
);

    logic [2*WORD_W-1:0] rot_pair;
    logic [2*WORD_W-1:0] rd_pair;
    logic [WORD_W-1:0]   rd_shift;
    logic [WE_W-1:0]     mask;
    logic [2*WE_W-1:0]   mask_sh;

    // Rotating the doubled word keeps every byte, so the same data serves both words of a split store.
    assign rot_pair    = {wdata_i, wdata_i} << {off_i, 3'b000};
    assign wdata_rot_o = rot_pair[2*WORD_W-1:WORD_W];

    assign rd_pair  = {hi_word_i, lo_word_i} >> {off_i, 3'b000};
    assign rd_shift = rd_pair[WORD_W-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; a default first rules out latches.
        mask = 4'b1111;
        case (funct3_i[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign mask_sh = {4'b0000, mask} << off_i;
    assign we_lo_o = mask_sh[WE_W-1:0];
    assign we_hi_o = mask_sh[2*WE_W-1:WE_W];

    always_comb begin
        rdata_ext_o = rd_shift;
        case (funct3_i)
            F3_B:    rdata_ext_o = {{(WORD_W-BYTE_W){rd_shift[BYTE_W-1]}}, rd_shift[BYTE_W-1:0]};
            F3_H:    rdata_ext_o = {{(WORD_W-HALF_W){rd_shift[HALF_W-1]}}, rd_shift[HALF_W-1:0]};
            F3_BU:   rdata_ext_o = {{(WORD_W-BYTE_W){1'b0}}, rd_shift[BYTE_W-1:0]};
            F3_HU:   rdata_ext_o = {{(WORD_W-HALF_W){1'b0}}, rd_shift[HALF_W-1:0]};
            default: rdata_ext_o = rd_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: one request at a time, misaligned accesses optionally split into two word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              split_q;
    logic [31:0]       lo_data_q;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              acc_legal;
    logic              acc_mis;
    logic [31:0]       lo_word_addr;
    logic [31:0]       hi_word_addr;
    logic [31:0]       wdata_rot;
    logic [WE_W-1:0]   we_lo;
    logic [WE_W-1:0]   we_hi;
    logic [31:0]       rdata_ext;

    assign accept    = req_valid && (state_q == S_IDLE);
    assign acc_legal = f3_legal(req_we, req_funct3);
    assign acc_mis   = is_misaligned(req_addr[1:0], req_funct3);

    assign lo_word_addr = {addr_q[31:2], 2'b00};
    assign hi_word_addr = lo_word_addr + 32'd4;

    // An unsplit access has only one word; mem_rdata in WAIT then supplies both halves of the pair.
    lsu_align u_align (
        .off_i       (addr_q[1:0]),
        .funct3_i    (funct3_q),
        .wdata_i     (wdata_q),
        .lo_word_i   (split_q ? lo_data_q : mem_rdata),
        .hi_word_i   (mem_rdata),
        .wdata_rot_o (wdata_rot),
        .we_lo_o     (we_lo),
        .we_hi_o     (we_hi),
        .rdata_ext_o (rdata_ext)
    );

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!acc_legal || (acc_mis && !SPLIT_EN)) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d = S_LO;
                    end
                end
            end
            S_LO:   state_d = split_q ? S_HI : S_WAIT;
            S_HI:   state_d = S_WAIT;
            S_WAIT: begin
                state_d      = S_RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 32'h0 : rdata_ext;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            split_q      <= 1'b0;
            lo_data_q    <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                split_q  <= SPLIT_EN && acc_mis;
            end
            if (state_q == S_HI) lo_data_q <= mem_rdata;
        end
    end

    // Memory-side outputs decode straight from state, so a reset silences the port in the same cycle.
    always_comb begin
        mem_addr  = 32'h0;
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        case (state_q)
            S_LO: begin
                mem_addr = lo_word_addr;
                if (we_q) begin
                    mem_we    = we_lo;
                    mem_wdata = wdata_rot;
                end
            end
            S_HI: begin
                mem_addr = hi_word_addr;
                if (we_q) begin
                    mem_we    = we_hi;
                    mem_wdata = wdata_rot;
                end
            end
            S_WAIT:  mem_addr = split_q ? hi_word_addr : lo_word_addr;
            default: mem_addr = 32'h0;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
